key_input_capture: RTL

- Front-end for user input; the counterpart of the seven-segment display driver.
- Debounces the confirm and cancel push-buttons and samples the DIP switches.
- Validates the sampled entry and delivers either an operation code or a digit value to the control FSM over a valid/ready handshake.
- Outputs use the same encodings the display driver consumes: op codes 0-3, digit values 0-15.

---
 rtl/key_input_capture.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_input_capture.sv
// key_input_capture: debounced button/switch front-end delivering op codes or digits over valid/ready
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_btn_confirm   raw confirm button, asynchronous, high = pressed
//   i_btn_cancel    raw cancel button, asynchronous, high = pressed
//   i_sw[3:0]       raw DIP switches, asynchronous
//   i_mode          0 = op entry, 1 = digit entry, sampled at capture
//   i_ready         consumer accepts the held entry
//   o_valid         entry held and stable
//   o_is_digit      i_mode at capture
//   o_op_code[2:0]  {1'b0, sw[1:0]} for op entries, else 0
//   o_digit_val[3:0] switch value for digit entries, else 0
//   o_err           one-cycle pulse, illegal entry rejected
//   o_cancel        one-cycle pulse, held entry cancelled by the user
// Optional: define KEY_AUTO_REPEAT_EN to re-capture every REPEAT_CYCLES while confirm stays held.
module key_input_capture #(
    parameter int DEB_CYCLES    = 16,
    parameter int MAX_DIGIT     = 15,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_confirm,
    input  logic       i_btn_cancel,
    input  logic [3:0] i_sw,
    input  logic       i_mode,
    input  logic       i_ready,
    output logic       o_valid,
    output logic       o_is_digit,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val,
    output logic       o_err,
    output logic       o_cancel
);
    localparam int DW = $clog2(DEB_CYCLES);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, WAIT_REL} state_t;
    state_t state, state_nx;
    // bit 0 = confirm, bit 1 = cancel
    logic [1:0] raw, s1, s2, deb, deb_q, press;
    logic [DW-1:0] cnt [2];
    logic [3:0] sw_s1, sw_s2;
    logic illegal, rep_hit;
    assign raw = {i_btn_cancel, i_btn_confirm};
    assign press = deb & ~deb_q;
    assign illegal = i_mode ? (32'(sw_s2) > MAX_DIGIT) : |sw_s2[3:2];
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            deb <= '0;
            deb_q <= '0;
            cnt <= '{default: '0};
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            deb_q <= deb;
            sw_s1 <= i_sw;
            sw_s2 <= sw_s1;
            // a level must disagree for DEB_CYCLES straight cycles before it is accepted
            for (int b = 0; b < 2; b++) begin
                if (s2[b] == deb[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == DW'(DEB_CYCLES - 1)) begin
                    cnt[b] <= '0;
                    deb[b] <= ~deb[b];
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end
`ifdef KEY_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt;
    // counter is zero on every WAIT_REL entry, so the first repeat comes REPEAT_CYCLES after entry
    assign rep_hit = state == WAIT_REL && deb[0] && rep_cnt == RW'(REPEAT_CYCLES - 1);
    always_ff @(posedge clk) begin
        rep_cnt <= (rst || state != WAIT_REL || !deb[0] || rep_hit) ? '0 : rep_cnt + 1'b1;
    end
`else
    // REPEAT_CYCLES only matters when auto-repeat is built in
    assign rep_hit = REPEAT_CYCLES < 0;
`endif
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = press[0] ? CAPTURE : IDLE;
            CAPTURE:  state_nx = illegal ? WAIT_REL : HOLD;
            HOLD:     state_nx = (i_ready || press[1]) ? WAIT_REL : HOLD;
            WAIT_REL: state_nx = !deb[0] ? IDLE : rep_hit ? CAPTURE : WAIT_REL;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        o_valid = state == HOLD;
        o_err = state == CAPTURE && illegal;
        // a transfer in the same cycle wins over the cancel
        o_cancel = state == HOLD && press[1] && !i_ready;
    end
    always_ff @(posedge clk) begin
        if (rst || (state == HOLD && state_nx != HOLD)) begin
            o_is_digit <= 1'b0;
            o_op_code <= '0;
            o_digit_val <= '0;
        end else if (state == CAPTURE && !illegal) begin
            o_is_digit <= i_mode;
            o_op_code <= i_mode ? 3'd0 : {1'b0, sw_s2[1:0]};
            o_digit_val <= i_mode ? sw_s2 : 4'd0;
        end
    end
endmodule
